// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// mux-select codes and the bundled datapath control word.
package mc_ctrl_pkg;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_RWB    = 4'd8;
  localparam logic [3:0] S_BEQ    = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_ADDIEX = 4'd11;
  localparam logic [3:0] S_ADDIWB = 4'd12;
  localparam logic [3:0] S_HALT   = 4'd13;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode: current state plus the memory
// handshake and ALU zero flag produce every datapath enable and select.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       zero,
  output ctrl_t      ctrl
);

  always_comb begin
    // NOTE: assign the whole word first so no branch leaves a bit unassigned and infers a latch.
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only capture once memory actually delivers the word.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
    ctrl.pc_en = ctrl.pc_write | (ctrl.pc_write_cond & zero);
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS sequencing FSM: holds the instruction-step state and
// fans the decoded control word out to the datapath.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter bit IDLE_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      ctrl;

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = IDLE_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from state_q, so forcing IDLE here also clears every enable asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  assign pc_en         = ctrl.pc_en;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign instr_done    = ctrl.instr_done;
  assign illegal_op    = (state_q == S_DECODE) && !is_known_op(opcode);
  assign state_dbg     = state_q;

endmodule
